fifo_read_streamer: RTL

Read-side consumer for the asynchronous FIFO, sitting entirely in the read clock domain. Pops words through the FIFO's rd_en/empty/rd_data port and re-presents them as a valid/ready stream with full backpressure. A 3-entry internal buffer absorbs the FIFO's one-cycle read latency, so the block sustains one word per cycle with no combinational path from `m_ready` to `fifo_rd_en`. Optionally frames the stream into fixed-length bursts with a `m_last` marker.

---
 rtl/fifo_rd_stream_pkg.sv | 14 +
 rtl/rd_stream_buffer.sv | 54 +++++
 rtl/fifo_read_streamer.sv | 84 ++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and helpers for the FIFO read-side streamer.
package fifo_rd_stream_pkg;

    localparam int unsigned BUF_DEPTH = 3;

    typedef logic [1:0] buf_idx_t;
    typedef logic [1:0] count_t;

    // Buffer indices run 0..BUF_DEPTH-1 and wrap back to 0.
    function automatic buf_idx_t ptr_inc(input buf_idx_t p);
        return (p == buf_idx_t'(BUF_DEPTH - 1)) ? '0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/rd_stream_buffer.sv
// Three-entry circular buffer that absorbs the FIFO read latency.
module rd_stream_buffer
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output count_t                count_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    buf_idx_t              wr_ptr_q, wr_ptr_d;
    buf_idx_t              rd_ptr_q, rd_ptr_d;
    count_t                count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_en_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        // Simultaneous write and pop leave the occupancy unchanged.
        case ({wr_en_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_read_streamer.sv
// Pops an async FIFO's read port and re-presents words as a valid/ready stream.
// Define FIFO_RD_STREAM_LAST_EN to frame the stream into BURST_LEN-word bursts via m_last.
module fifo_read_streamer
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    if (BURST_LEN < 2) begin : g_bad_burst_len
        $error("BURST_LEN must be 2 or more");
    end

    logic                  inflight_q;
    count_t                count;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;
    logic [2:0]            occupancy;

    // Slots already buffered plus the word still on its way from the FIFO.
    assign occupancy  = {1'b0, count} + {2'b00, inflight_q};
    assign fifo_rd_en = !rst && !fifo_empty && (occupancy < 3'(BUF_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
        end
    end

    rd_stream_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (inflight_q),
        .wr_data_i (fifo_rd_data),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (count)
    );

    assign m_valid = (count != '0);
    assign m_data  = head;
    assign pop     = m_valid && m_ready;

`ifdef FIFO_RD_STREAM_LAST_EN
    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    typedef logic [BEAT_W-1:0] beat_t;

    beat_t beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == beat_t'(BURST_LEN - 1)) ? '0 : beat_q + beat_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign m_last = m_valid && (beat_q == beat_t'(BURST_LEN - 1));
`else
    assign m_last = 1'b0;
`endif

endmodule
